// File: rtl/la_ioanalog_seq.sv
// rtl/la_ioanalog_seq.sv - analog pad tap sequencer: break-before-make, settle, one ADC conversion
// Returns one sample (or an error) per accepted request over a valid/ready response channel.
module la_ioanalog_seq #(
    parameter int N       = 4,
    parameter int CW      = 2,
    parameter int SW      = 8,
    parameter int DW      = 12,
    parameter int BBM     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CW-1:0]   req_chan,
    input  logic [1:0]      req_tap,
    input  logic [SW-1:0]   req_settle,
    output logic [3*N-1:0]  sel_en,
    output logic            adc_start,
    input  logic            adc_done,
    input  logic [DW-1:0]   adc_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic [CW-1:0]   rsp_chan,
    output logic            rsp_err
);

    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int BW    = $clog2(BBM + 1);
    localparam int MW    = (SW > TW) ? SW : TW;
    localparam int CNTW  = (MW > BW) ? MW : BW;
    localparam logic [CW:0]    NLIM    = (CW + 1)'(N);
    localparam logic [3*N-1:0] SEL_ONE = (3 * N)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_SETTLE,
        S_CONVERT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic [1:0]      tap_q, tap_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [3*N-1:0]  sel_en_q, sel_en_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [CW-1:0]   rsp_chan_q, rsp_chan_d;
    logic            rsp_err_q, rsp_err_d;
    logic            req_illegal;
    logic [3*N-1:0]  sel_onehot;

    assign req_illegal = (req_tap == 2'd3) || ({1'b0, req_chan} >= NLIM);
    // Only ever evaluated for a legal latched chan/tap, so the shift stays in range.
    assign sel_onehot  = SEL_ONE << (int'(chan_q) * 3 + int'(tap_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        tap_d      = tap_q;
        settle_d   = settle_q;
        sel_en_d   = sel_en_q;
        rsp_data_d = rsp_data_q;
        rsp_chan_d = rsp_chan_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 1'b0;
        adc_start  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    chan_d   = req_chan;
                    tap_d    = req_tap;
                    settle_d = req_settle;
                    cnt_d    = '0;
                    sel_en_d = '0;
                    if (req_illegal) begin
                        rsp_data_d = '0;
                        rsp_chan_d = req_chan;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (cnt_q == CNTW'(BBM - 1)) begin
                    cnt_d    = '0;
                    sel_en_d = sel_onehot;
                    state_d  = (settle_q == '0) ? S_CONVERT : S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_SETTLE: begin
                if ((cnt_q + CNTW'(1)) == CNTW'(settle_q)) begin
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_CONVERT: begin
                // cnt_q counts sampling cycles; the start cycle itself never samples adc_done.
                adc_start = (cnt_q == '0);
                if ((cnt_q != '0) && adc_done) begin
                    rsp_data_d = adc_data;
                    rsp_chan_d = chan_q;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == CNTW'(TIMEOUT)) begin
                    rsp_data_d = '0;
                    rsp_chan_d = chan_q;
                    rsp_err_d  = 1'b1;
                    sel_en_d   = '0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            chan_q     <= '0;
            tap_q      <= '0;
            settle_q   <= '0;
            sel_en_q   <= '0;
            rsp_data_q <= '0;
            rsp_chan_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chan_q     <= chan_d;
            tap_q      <= tap_d;
            settle_q   <= settle_d;
            sel_en_q   <= sel_en_d;
            rsp_data_q <= rsp_data_d;
            rsp_chan_q <= rsp_chan_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign sel_en    = sel_en_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_chan  = rsp_chan_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_la_ioanalog_seq.sv
// tb/tb_la_ioanalog_seq.sv - scoreboard bench for la_ioanalog_seq
// Directed requests push expected responses; a forked monitor pops them on each handshake.
module tb_la_ioanalog_seq;

    localparam int N       = 4;
    localparam int CW      = 3;
    localparam int SW      = 8;
    localparam int DW      = 12;
    localparam int BBM     = 2;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [CW-1:0]   req_chan;
    logic [1:0]      req_tap;
    logic [SW-1:0]   req_settle;
    logic [3*N-1:0]  sel_en;
    logic            adc_start;
    logic            adc_done;
    logic [DW-1:0]   adc_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [CW-1:0]   rsp_chan;
    logic            rsp_err;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] chan;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   n_start = 0;

    la_ioanalog_seq #(
        .N(N), .CW(CW), .SW(SW), .DW(DW), .BBM(BBM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
        .req_tap(req_tap), .req_settle(req_settle),
        .sel_en(sel_en), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_chan(rsp_chan), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !req_ready; i++) step();
        chk("wait_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic issue(input int ch, input int tp, input int st);
        wait_ready();
        req_valid  = 1'b1;
        req_chan   = CW'(ch);
        req_tap    = 2'(tp);
        req_settle = SW'(st);
        step();
        req_valid  = 1'b0;
    endtask

    // Full legal request with cycle-by-cycle checks; dd = sampling cycles until done.
    task automatic run_req(input string tag, input int ch, input int tp, input int st,
                           input int dd, input bit hold, input logic [DW-1:0] data);
        int startk;
        logic [3*N-1:0] oh;
        startk = BBM + st + 1;
        oh     = (3 * N)'(1) << (ch * 3 + tp);
        exp_q.push_back({data, CW'(ch), 1'b0});
        issue(ch, tp, st);
        for (int k = 1; k <= startk + dd + 1; k++) begin
            adc_done = hold ? (k >= startk) : (k == startk + dd);
            adc_data = adc_done ? data : 12'hFFF;
            chk({tag, "_sel_en"}, 32'(sel_en), (k <= BBM) ? 32'd0 : 32'(oh));
            chk({tag, "_adc_start"}, 32'(adc_start), 32'(k == startk));
            chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(k == startk + dd + 1));
            step();
        end
        adc_done = 1'b0;
    endtask

    initial begin
        int ns;
        int m;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_chan   = '0;
        req_tap    = '0;
        req_settle = '0;
        adc_done   = 1'b0;
        adc_data   = '0;
        rsp_ready  = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (adc_start) n_start++;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected: act=%0h/%0h/%0h req=none",
                                 rsp_data, rsp_chan, rsp_err);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_data", 32'(rsp_data), 32'(e.data));
                        chk("rsp_chan", 32'(rsp_chan), 32'(e.chan));
                        chk("rsp_err",  32'(rsp_err),  32'(e.err));
                    end
                end
            end
        join_none

        step(); step(); step();
        reset = 1'b0;
        chk("rst_sel_en",    32'(sel_en),    32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_chan",  32'(rsp_chan),  32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_adc_start", 32'(adc_start), 32'd0);

        // Nominal: chan2/tap1 -> bit 7, settle 3, done in cycle 9
        run_req("nom", 2, 1, 3, 3, 1'b0, 12'hABC);
        chk("nom_idle_sel_en", 32'(sel_en), 32'h080);

        // Illegal tap, then illegal channel
        ns = n_start;
        exp_q.push_back({12'h000, CW'(1), 1'b1});
        issue(1, 3, 4);
        chk("ill_tap_valid",  32'(rsp_valid), 32'd1);
        chk("ill_tap_sel_en", 32'(sel_en),    32'd0);
        step();
        exp_q.push_back({12'h000, CW'(5), 1'b1});
        issue(5, 0, 4);
        chk("ill_chan_valid",  32'(rsp_valid), 32'd1);
        chk("ill_chan_sel_en", 32'(sel_en),    32'd0);
        step();
        step();
        chk("ill_no_start", 32'(n_start), 32'(ns));

        // Timeout: no adc_done -> response after TIMEOUT sampling cycles
        exp_q.push_back({12'h000, CW'(3), 1'b1});
        issue(3, 2, 1);
        for (int i = 0; i < 40 && !adc_start; i++) step();
        chk("to_start_seen", 32'(adc_start), 32'd1);
        step();
        m = 1;
        while (!rsp_valid && m < 40) begin
            step();
            m++;
        end
        chk("to_latency", 32'(m), 32'(TIMEOUT + 1));
        step();

        // Backpressure: response held 20 cycles, req_* ignored meanwhile
        rsp_ready = 1'b0;
        exp_q.push_back({12'h5A5, CW'(1), 1'b0});
        issue(1, 0, 2);
        for (int i = 0; i < 40 && !adc_start; i++) step();
        chk("bp_start_seen", 32'(adc_start), 32'd1);
        step();
        adc_done = 1'b1;
        adc_data = 12'h5A5;
        step();
        adc_done  = 1'b0;
        req_valid = 1'b1;
        req_chan  = CW'(0);
        req_tap   = 2'd0;
        for (int i = 0; i < 20; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_data",  32'(rsp_data),  32'h5A5);
            chk("bp_sel_en",    32'(sel_en),    32'h008);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_ready", 32'(req_ready), 32'd1);

        // Back-to-back identical selections still get the open BBM window
        run_req("b2b_a", 0, 0, 1, 2, 1'b0, 12'h111);
        run_req("b2b_b", 0, 0, 1, 1, 1'b0, 12'h222);

        // settle=0 with adc_done high from the start cycle
        run_req("s0", 3, 0, 0, 1, 1'b1, 12'h3C3);

        // Reset in the middle of SETTLE aborts without start or response
        issue(2, 2, 10);
        step(); step(); step();
        ns = n_start;
        reset = 1'b1;
        step();
        chk("mrst_sel_en_a",    32'(sel_en),    32'd0);
        chk("mrst_rsp_valid_a", 32'(rsp_valid), 32'd0);
        step();
        chk("mrst_sel_en_b",    32'(sel_en),    32'd0);
        step();
        reset = 1'b0;
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        chk("mrst_sel_en_c",  32'(sel_en),    32'd0);
        for (int i = 0; i < 20; i++) step();
        chk("mrst_no_start", 32'(n_start), 32'(ns));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
